spart_driver: RTL and testbench
===============================

Name: spart_driver

Overview:
- Processor-side stand-in that sits directly upstream of the SPART on its I/O bus (iocs/iorw/ioaddr/databus, rda/tbr).
- After reset it programs the baud divisor selected by the board switches (br_cfg), then runs an echo loop: when rda is high it reads the received byte, waits for tbr, and writes the byte back for transmission.
- It also exposes the last echoed byte and an echo count for LEDs/debug.

Parameters:
- DIV_4800, 16'd1042, divisor for br_cfg=2'b00
- DIV_9600, 16'd521, divisor for br_cfg=2'b01
- DIV_19200, 16'd260, divisor for br_cfg=2'b10
- DIV_38400, 16'd130, divisor for br_cfg=2'b11

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- br_cfg  input  2  baud select from switches; asynchronous to clk
- rda  input  1  SPART receive data available
- tbr  input  1  SPART transmit buffer ready
- iocs  output  1  SPART chip select
- iorw  output  1  1 = read, 0 = write
- ioaddr  output  2  00 = TX/RX buffer, 01 = status, 10 = divisor low, 11 = divisor high
- databus  inout  8  driven only when iocs=1 and iorw=0; otherwise high-Z
- last_byte  output  8  last byte read from the SPART
- echo_cnt  output  8  count of completed echoes; wraps from 255 to 0

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: iocs=0, iorw=1, ioaddr=00, databus=Z, last_byte=0, echo_cnt=0.
  - Internal: state=INIT, br_sync=00, br_prog=00.
- br_cfg synchronizer:
  - Two-flop synchronizer into br_sync.
  - br_prog holds the value last programmed into the SPART.
  - cfg_change = (br_sync != br_prog).
- Divisor: selected combinationally from br_sync using the DIV_* parameters.
- Bus cycles: every access is exactly one clk cycle with iocs=1. In all other cycles iocs=0, iorw=1, ioaddr=00, and databus is released.
- State machine:
  - INIT: idle for 2 cycles after reset release so br_sync settles, then go to DB_LO.
  - DB_LO: iocs=1, iorw=0, ioaddr=10, databus=divisor[7:0]; next DB_HI.
  - DB_HI: iocs=1, iorw=0, ioaddr=11, databus=divisor[15:8]; latch br_prog<=br_sync; next IDLE.
  - IDLE, in priority order:
    - cfg_change -> DB_LO.
    - Else rda=1 -> READ.
    - Else stay in IDLE.
  - READ: iocs=1, iorw=1, ioaddr=00; sample databus into last_byte at the end of the cycle; next WAIT_TBR.
  - WAIT_TBR: tbr=1 -> WRITE; otherwise stay. cfg_change is ignored in this state.
  - WRITE: iocs=1, iorw=0, ioaddr=00, databus=last_byte; echo_cnt<=echo_cnt+1; next IDLE.
- Latency:
  - Reset release to first DB_LO cycle: 3 cycles.
  - rda seen in IDLE to READ: 1 cycle.
  - READ to WRITE: at least 2 cycles (when tbr is already high).
- Boundary conditions:
  - rda and tbr both high in IDLE: read first; never write before a read.
  - br_cfg change during READ/WAIT_TBR/WRITE: finish the echo, then reprogram from IDLE before the next READ.
  - br_cfg toggling faster than reprogramming: the value sampled in DB_LO is used for both divisor bytes; any remaining mismatch triggers another reprogram.
  - Reset mid-access: databus released and iocs=0 immediately (asynchronously); last_byte is lost.
  - rda still high on return to IDLE: another READ is issued; the driver does not de-duplicate.
  - DB_LO and DB_HI are never split by a READ.

Test Plan:
- Reset release with br_cfg=01 -> write 0x09 to addr 10, then write 0x02 to addr 11 on consecutive cycles starting cycle 3; then IDLE with iocs=0.
- In IDLE, bus model presents 0x5A, pulses rda, tbr=1 -> one read at addr 00, then write of 0x5A at addr 00; last_byte=0x5A, echo_cnt=1.
- Hold tbr=0 for 50 cycles after a read of 0xC3 -> no write and databus stays Z; tbr rises -> write 0xC3 on the next cycle.
- Change br_cfg 01->11 while in WAIT_TBR -> echo completes first, then writes 0x82 to addr 10 and 0x00 to addr 11; no READ between them.
- Assert rst during WRITE -> iocs=0 and databus=Z in the same cycle; after release, the divisor sequence repeats.
- 256 echoes -> echo_cnt returns to 0x00.

Source files
------------

// File: rtl/spart_driver_if.sv
// SPART I/O bus between the driver (master) and the SPART or a bus model (slave).
// The shared databus is resolved here so each side only drives its own data/enable pair.
interface spart_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;
  logic [7:0] db_o;
  logic       db_oe;
  logic [7:0] slv_d;
  logic       slv_oe;
  wire  [7:0] databus;

  // Driver wins if both sides enable; that cannot happen, since the slave drives only on reads.
  assign databus = db_oe ? db_o : (slv_oe ? slv_d : 8'bz);

  modport master (
    output iocs, iorw, ioaddr, db_o, db_oe,
    input  rda, tbr, databus
  );

  modport slave (
    input  iocs, iorw, ioaddr, db_o, db_oe,
    output rda, tbr, slv_d, slv_oe,
    input  databus
  );
endinterface

// File: rtl/spart_driver.sv
// Processor stand-in for the SPART: programs the switch-selected baud divisor,
// then echoes every received byte back to the transmitter.
module spart_driver #(
  parameter logic [15:0] DIV_4800  = 16'd1042,
  parameter logic [15:0] DIV_9600  = 16'd521,
  parameter logic [15:0] DIV_19200 = 16'd260,
  parameter logic [15:0] DIV_38400 = 16'd130
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     br_cfg,
  spart_driver_if.master bus,
  output logic [7:0]     last_byte,
  output logic [7:0]     echo_cnt
);

  typedef enum logic [2:0] {
    INIT, DB_LO, DB_HI, IDLE, READ, WAIT_TBR, WRITE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  init_cnt_q, init_cnt_d;
  logic [1:0]  br_meta_q, br_sync_q;
  logic [1:0]  br_prog_q, br_prog_d;
  logic [1:0]  br_lat_q, br_lat_d;
  logic [15:0] div_q, div_d, div_sel;
  logic [7:0]  last_q, last_d;
  logic [7:0]  echo_q, echo_d;
  logic [7:0]  db_q, db_d;
  logic        iocs_q, iocs_d;
  logic        iorw_q, iorw_d;
  logic        oe_q, oe_d;
  logic [1:0]  addr_q, addr_d;
  logic        cfg_change;
  logic        enter_lo;

  function automatic logic [15:0] div_lookup(input logic [1:0] sel);
    case (sel)
      2'b00:   div_lookup = DIV_4800;
      2'b01:   div_lookup = DIV_9600;
      2'b10:   div_lookup = DIV_19200;
      default: div_lookup = DIV_38400;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_meta_q <= 2'b00;
      br_sync_q <= 2'b00;
    end else begin
      br_meta_q <= br_cfg;
      br_sync_q <= br_meta_q;
    end
  end

  assign div_sel    = div_lookup(br_sync_q);
  assign cfg_change = (br_sync_q != br_prog_q);

  // Bus outputs are registered together with the state they belong to, so the
  // *_d values describe the access performed in the cycle after the edge.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    br_prog_d  = br_prog_q;
    br_lat_d   = br_lat_q;
    div_d      = div_q;
    last_d     = last_q;
    echo_d     = echo_q;
    db_d       = db_q;
    iocs_d     = 1'b0;
    iorw_d     = 1'b1;
    addr_d     = 2'b00;
    oe_d       = 1'b0;
    enter_lo   = 1'b0;

    case (state_q)
      INIT: begin
        if (init_cnt_q == 2'd2) begin
          enter_lo = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + 2'd1;
        end
      end
      DB_LO: begin
        state_d = DB_HI;
        iocs_d  = 1'b1;
        iorw_d  = 1'b0;
        addr_d  = 2'b11;
        oe_d    = 1'b1;
        db_d    = div_q[15:8];
      end
      DB_HI: begin
        br_prog_d = br_lat_q;
        state_d   = IDLE;
      end
      IDLE: begin
        if (cfg_change) begin
          enter_lo = 1'b1;
        end else if (bus.rda) begin
          state_d = READ;
          iocs_d  = 1'b1;
          iorw_d  = 1'b1;
          addr_d  = 2'b00;
        end
      end
      READ: begin
        last_d  = bus.databus;
        state_d = WAIT_TBR;
      end
      WAIT_TBR: begin
        if (bus.tbr) begin
          state_d = WRITE;
          iocs_d  = 1'b1;
          iorw_d  = 1'b0;
          addr_d  = 2'b00;
          oe_d    = 1'b1;
          db_d    = last_q;
        end
      end
      WRITE: begin
        echo_d  = echo_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase

    // The divisor is captured once on entry so both bytes come from the same setting.
    if (enter_lo) begin
      state_d  = DB_LO;
      div_d    = div_sel;
      br_lat_d = br_sync_q;
      iocs_d   = 1'b1;
      iorw_d   = 1'b0;
      addr_d   = 2'b10;
      oe_d     = 1'b1;
      db_d     = div_sel[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= INIT;
      init_cnt_q <= 2'd0;
      br_prog_q  <= 2'b00;
      br_lat_q   <= 2'b00;
      div_q      <= 16'd0;
      last_q     <= 8'd0;
      echo_q     <= 8'd0;
      db_q       <= 8'd0;
      iocs_q     <= 1'b0;
      iorw_q     <= 1'b1;
      addr_q     <= 2'b00;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      br_prog_q  <= br_prog_d;
      br_lat_q   <= br_lat_d;
      div_q      <= div_d;
      last_q     <= last_d;
      echo_q     <= echo_d;
      db_q       <= db_d;
      iocs_q     <= iocs_d;
      iorw_q     <= iorw_d;
      addr_q     <= addr_d;
      oe_q       <= oe_d;
    end
  end

  assign bus.iocs   = iocs_q;
  assign bus.iorw   = iorw_q;
  assign bus.ioaddr = addr_q;
  assign bus.db_o   = db_q;
  assign bus.db_oe  = oe_q;
  assign last_byte  = last_q;
  assign echo_cnt   = echo_q;

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: a queue of expected bus accesses plus a last-byte/echo-count
// model, compared every cycle, with directed literal checks on key cycles.
module tb_spart_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] br_cfg = 2'b01;
  logic [7:0] last_byte, echo_cnt;
  logic [7:0] rx_byte = 8'h00;

  spart_driver_if bif();

  assign bif.slv_oe = bif.iocs & bif.iorw;
  assign bif.slv_d  = rx_byte;

  spart_driver dut (
    .clk       (clk),
    .rst       (rst),
    .br_cfg    (br_cfg),
    .bus       (bif),
    .last_byte (last_byte),
    .echo_cnt  (echo_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rd;
    logic [1:0] addr;
    logic [7:0] data;
  } acc_t;

  acc_t       exp_q[$];
  logic [15:0] div_tab [4] = '{16'd1042, 16'd521, 16'd260, 16'd130};
  logic [7:0] m_last = 8'h00;
  logic [7:0] m_cnt  = 8'h00;
  int         n_pass = 0;
  int         n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input logic rd, input logic [1:0] addr, input logic [7:0] data);
    acc_t e;
    e.rd = rd; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_div(input logic [1:0] cfg);
    logic [15:0] d;
    d = div_tab[cfg];
    push(1'b0, 2'b10, d[7:0]);
    push(1'b0, 2'b11, d[15:8]);
  endtask

  task automatic wait_q(input int sz, input int maxc, input string name);
    int n = 0;
    while (exp_q.size() > sz && n < maxc) begin
      @(posedge clk);
      n++;
    end
    chk(name, exp_q.size(), sz);
  endtask

  task automatic pulse_rda();
    @(negedge clk); bif.rda = 1'b1;
    @(negedge clk); bif.rda = 1'b0;
  endtask

  task automatic do_reset(input logic [1:0] cfg);
    logic [15:0] d;
    d = div_tab[cfg];
    br_cfg = cfg;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    push_div(cfg);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("init_quiet", bif.iocs, 1'b0);
    end
    @(posedge clk); #1;
    chk("first_db_lo", {bif.iocs, bif.iorw, bif.ioaddr, bif.databus}, {1'b1, 1'b0, 2'b10, d[7:0]});
    wait_q(0, 10, "div_drain");
  endtask

  // Per-cycle compare against the access queue and the last-byte/echo-count model.
  always @(negedge clk) begin
    acc_t e;
    if (!rst) begin
      exp_q.delete();
      m_last = 8'h00;
      m_cnt  = 8'h00;
      chk("rst_bus", {bif.iocs, bif.iorw, bif.ioaddr, bif.db_oe}, 5'b01000);
      chk("rst_regs", {last_byte, echo_cnt}, 16'h0000);
    end else begin
      chk("last_byte", last_byte, m_last);
      chk("echo_cnt", echo_cnt, m_cnt);
      if (bif.iocs) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_access", {bif.iorw, bif.ioaddr}, 3'b000);
        end else begin
          e = exp_q.pop_front();
          chk("acc_kind", {bif.iorw, bif.ioaddr}, {e.rd, e.addr});
          if (e.rd) begin
            chk("rd_release", bif.db_oe, 1'b0);
            m_last = e.data;
          end else begin
            chk("wr_data", {bif.db_oe, bif.databus}, {1'b1, e.data});
            if (e.addr == 2'b00) m_cnt = m_cnt + 8'd1;
          end
        end
      end else begin
        chk("idle_bus", {bif.iorw, bif.ioaddr, bif.db_oe}, 4'b1000);
      end
    end
  end

  initial begin
    int wr_seen;
    bif.rda = 1'b0;
    bif.tbr = 1'b0;

    // Reset release with 9600 baud: 521 = 0x0209.
    do_reset(2'b01);
    repeat (3) @(posedge clk); #1;
    chk("div9600_idle", bif.iocs, 1'b0);

    // Single echo with tbr already high.
    bif.tbr = 1'b1;
    rx_byte = 8'h5A;
    push(1'b1, 2'b00, 8'h5A);
    push(1'b0, 2'b00, 8'h5A);
    pulse_rda();
    wait_q(0, 20, "echo_5a");
    @(posedge clk); #1;
    chk("lit_last_5a", last_byte, 8'h5A);
    chk("lit_cnt_1", echo_cnt, 8'd1);

    // Transmitter busy for 50 cycles after reading 0xC3.
    @(negedge clk); bif.tbr = 1'b0;
    rx_byte = 8'hC3;
    push(1'b1, 2'b00, 8'hC3);
    push(1'b0, 2'b00, 8'hC3);
    pulse_rda();
    wait_q(1, 20, "read_c3");
    wr_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (bif.iocs || bif.db_oe) wr_seen++;
    end
    chk("no_write_while_busy", wr_seen, 0);
    @(negedge clk); bif.tbr = 1'b1;
    @(posedge clk); #1;
    chk("lit_write_c3", {bif.iocs, bif.iorw, bif.ioaddr, bif.databus}, {1'b1, 1'b0, 2'b00, 8'hC3});
    wait_q(0, 5, "write_c3");

    // Baud change 01->11 while waiting for tbr: echo first, then 130 = 0x0082.
    @(negedge clk); bif.tbr = 1'b0;
    rx_byte = 8'hE1;
    push(1'b1, 2'b00, 8'hE1);
    push(1'b0, 2'b00, 8'hE1);
    push(1'b0, 2'b10, 8'h82);
    push(1'b0, 2'b11, 8'h00);
    pulse_rda();
    wait_q(3, 20, "read_e1");
    br_cfg = 2'b11;
    repeat (10) @(posedge clk);
    chk("held_in_wait", exp_q.size(), 3);
    @(negedge clk); bif.tbr = 1'b1;
    wait_q(0, 20, "echo_then_reprog");

    // Reprogram from IDLE to 4800: 1042 = 0x0412.
    @(negedge clk);
    push_div(2'b00);
    br_cfg = 2'b00;
    wait_q(0, 20, "reprog_4800");

    // Reset asserted during a WRITE.
    @(negedge clk); bif.tbr = 1'b0;
    rx_byte = 8'h77;
    push(1'b1, 2'b00, 8'h77);
    push(1'b0, 2'b00, 8'h77);
    pulse_rda();
    wait_q(1, 20, "read_77");
    @(negedge clk); bif.tbr = 1'b1;
    @(posedge clk); #1;
    chk("write_77_live", {bif.iocs, bif.iorw, bif.db_oe}, 3'b101);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_bus", {bif.iocs, bif.db_oe}, 2'b00);
    chk("async_rst_last", last_byte, 8'h00);
    do_reset(2'b11);

    // 256 echoes wrap the counter.
    for (int i = 0; i < 256; i++) begin
      rx_byte = i[7:0];
      push(1'b1, 2'b00, i[7:0]);
      push(1'b0, 2'b00, i[7:0]);
      pulse_rda();
      wait_q(0, 20, "echo_loop");
      if (i == 254) begin
        @(posedge clk); #1;
        chk("lit_cnt_255", echo_cnt, 8'd255);
      end
    end
    @(posedge clk); #1;
    chk("lit_cnt_wrap", echo_cnt, 8'd0);
    chk("lit_last_ff", last_byte, 8'hFF);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
